// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB write-back select and 2**ADDR_W x WIDTH register file with commit counter.
// Define REGFILE_BYPASS_EN to compile in the same-cycle write-through path on RD1/RD2.
module wb_regfile #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic [WIDTH-1:0]  ALUResultW,
    input  logic [WIDTH-1:0]  ReadDataW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic [WIDTH-1:0]  ResultW,
    output logic [WIDTH-1:0]  DbgData,
    output logic [31:0]       WriteCount
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [31:0]      r_count;
    logic             w_commit;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    assign ResultW  = MemtoRegW ? ReadDataW : ALUResultW;
    assign w_commit = RegWriteW && (WriteRegW != '0) && !reset;

    // Entry 0 is cleared by reset and never written, so it is constant zero.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_count <= '0;
        end else if (w_commit) begin
            r_regs[WriteRegW] <= ResultW;
            r_count           <= r_count + 32'd1;
        end
    end

    assign w_rd1      = (A1 == '0) ? '0 : r_regs[A1];
    assign w_rd2      = (A2 == '0) ? '0 : r_regs[A2];
    assign DbgData    = (DbgAddr == '0) ? '0 : r_regs[DbgAddr];
    assign WriteCount = r_count;

`ifdef REGFILE_BYPASS_EN
    // w_commit already excludes register 0 and reset, so the bypass inherits both.
    assign RD1 = (w_commit && WriteRegW == A1) ? ResultW : w_rd1;
    assign RD2 = (w_commit && WriteRegW == A2) ? ResultW : w_rd2;
`else
    assign RD1 = w_rd1;
    assign RD2 = w_rd2;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against a behavioural model.
module tb_wb_regfile;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ALUResultW, ReadDataW;
    logic [4:0]  WriteRegW, A1, A2, DbgAddr;
    logic [31:0] RD1, RD2, ResultW, DbgData, WriteCount;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    wb_regfile #(.WIDTH(32), .ADDR_W(5)) dut (
        .CLK(CLK), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
        .A1(A1), .A2(A2), .DbgAddr(DbgAddr), .RD1(RD1), .RD2(RD2),
        .ResultW(ResultW), .DbgData(DbgData), .WriteCount(WriteCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_result();
        return MemtoRegW ? ReadDataW : ALUResultW;
    endfunction

    function automatic logic m_commit();
        return RegWriteW && WriteRegW != 0 && !reset;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && m_commit() && WriteRegW == a) return m_result();
        return m_regs[a];
    endfunction

    always @(posedge reset) begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_count = 32'h0;
    end

    always @(posedge CLK) begin
        if (m_commit()) begin
            m_regs[WriteRegW] = m_result();
            m_count           = m_count + 32'd1;
        end
    end

    always @(negedge CLK) begin
        chk("cmp_resultw", ResultW, m_result());
        chk("cmp_rd1", RD1, m_read(A1, BYP));
        chk("cmp_rd2", RD2, m_read(A2, BYP));
        chk("cmp_dbg", DbgData, m_read(DbgAddr, 1'b0));
        chk("cmp_count", WriteCount, m_count);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [4:0] wr);
        RegWriteW = we; MemtoRegW = m2r; ALUResultW = alu; ReadDataW = rd; WriteRegW = wr;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h5A5A_5A5A, 32'h0, 5'd4);
        A1 = 5'd4; A2 = 5'd4; DbgAddr = 5'd4;
        step(); step();
        chk("rst_rd1", RD1, 32'h0);
        chk("rst_count", WriteCount, 32'h0);
        reset = 1'b0;

        // async reset clears regs[5] and counter without a clock edge
        drive(1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd5);
        A1 = 5'd5;
        step();
        RegWriteW = 1'b0;
        #1;
        chk("pre_rst_rd1", RD1, 32'h1234_5678);
        chk("pre_rst_count", WriteCount, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_rd1", RD1, 32'h0);
        chk("async_rst_count", WriteCount, 32'h0);
        #1 reset = 1'b0;
        step();

        drive(1'b1, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF, 5'd7);
        A2 = 5'd7;
        #1;
        chk("sel_load", ResultW, 32'hDEAD_BEEF);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("wr_load_rd2", RD2, 32'hDEAD_BEEF);
        chk("wr_load_count", WriteCount, 32'd1);
        drive(1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd7);
        #1;
        chk("sel_alu", ResultW, 32'h1111_1111);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("wr_alu_rd2", RD2, 32'h1111_1111);
        chk("wr_alu_count", WriteCount, 32'd2);

        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0);
        A1 = 5'd0;
        step();
        RegWriteW = 1'b0;
        #1;
        chk("r0_rd1", RD1, 32'h0);
        chk("r0_count", WriteCount, 32'd2);

        drive(1'b1, 1'b0, 32'hA, 32'h0, 5'd9);
        step();
        drive(1'b1, 1'b0, 32'hB, 32'h0, 5'd9);
        A1 = 5'd9; A2 = 5'd9; DbgAddr = 5'd9;
        #1;
        chk("haz_rd1", RD1, BYP ? 32'hB : 32'hA);
        chk("haz_rd2", RD2, BYP ? 32'hB : 32'hA);
        chk("haz_dbg", DbgData, 32'hA);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("haz_next_rd1", RD1, 32'hB);
        chk("haz_next_rd2", RD2, 32'hB);
        chk("haz_next_dbg", DbgData, 32'hB);
        chk("haz_count", WriteCount, 32'd4);

        drive(1'b0, 1'b0, 32'h55, 32'h0, 5'd3);
        A1 = 5'd3;
        step();
        #1;
        chk("gate_rd1", RD1, 32'h0);
        chk("gate_count", WriteCount, 32'd4);

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom,
                  5'($urandom_range(0, 7)));
            A1      = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom_range(0, 7));
            A2      = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom);
            DbgAddr = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #6 reset = 1'b0;
            end
            step();
        end

        RegWriteW = 1'b0;
        dut.r_count = 32'hFFFF_FFFE;
        m_count     = 32'hFFFF_FFFE;
        #1;
        chk("wrap_preload", WriteCount, 32'hFFFF_FFFE);
        drive(1'b1, 1'b0, 32'h77, 32'h0, 5'd12);
        step(); step();
        RegWriteW = 1'b0;
        #1;
        chk("wrap_count", WriteCount, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
